// File: rtl/sound_mixer_if.sv
// sound_mixer_if: CPU-side write port and buzzer outputs of the tone mixer.
//   wr_en          single-cycle write strobe
//   wr_channel     channel index to write
//   wr_max_count   half-period minus one; 0 stops the channel
//   wr_duration    ticks to play; 0 plays until rewritten
//   channel_active per-channel playing flag (registered)
//   buzzer         registered mixed output
interface sound_mixer_if #(
    parameter int CHANNELS    = 4,
    parameter int COUNT_WIDTH = 26,
    parameter int DUR_WIDTH   = 16
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic                   wr_en;
    logic [CW-1:0]          wr_channel;
    logic [COUNT_WIDTH-1:0] wr_max_count;
    logic [DUR_WIDTH-1:0]   wr_duration;
    logic [CHANNELS-1:0]    channel_active;
    logic                   buzzer;
    modport master (output wr_en, wr_channel, wr_max_count, wr_duration,
                    input  channel_active, buzzer);
    modport slave  (input  wr_en, wr_channel, wr_max_count, wr_duration,
                    output channel_active, buzzer);
endinterface

// File: rtl/sound_mixer.sv
// sound_mixer: CHANNELS square-wave tone generators with auto-stop, mixed onto one buzzer pin.
//   clk   system clock
//   n_rst synchronous active-low reset
//   bus   sound_mixer_if.slave: write port in, channel_active/buzzer out
module sound_mixer #(
    parameter int CHANNELS     = 4,
    parameter int COUNT_WIDTH  = 26,
    parameter int DUR_WIDTH    = 16,
    parameter int TICK_DIVISOR = 50000,
    parameter int MIX_MODE     = 0,
    parameter int SLICE_CYCLES = 256
) (
    input logic        clk,
    input logic        n_rst,
    sound_mixer_if.slave bus
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int TW = $clog2(TICK_DIVISOR);
    localparam int SW = SLICE_CYCLES > 1 ? $clog2(SLICE_CYCLES) : 1;
    logic [COUNT_WIDTH-1:0] max_count [CHANNELS];
    logic [COUNT_WIDTH-1:0] phase     [CHANNELS];
    logic [DUR_WIDTH-1:0]   remaining [CHANNELS];
    logic [CHANNELS-1:0]    tone, active;
    logic [TW-1:0]          tick_cnt;
    logic [SW-1:0]          slice_cnt;
    logic [CW-1:0]          slot;
    logic                   tick, slice_end, wr_ok, mix;
    assign tick      = tick_cnt == TW'(TICK_DIVISOR - 1);
    assign slice_end = slice_cnt == SW'(SLICE_CYCLES - 1);
    assign wr_ok     = bus.wr_en && int'(bus.wr_channel) < CHANNELS;
    // Round-robin visits every slot, active or not, so slot timing never depends on traffic.
    assign mix = MIX_MODE != 0 ? tone[slot] & active[slot] : |(tone & active);
    assign bus.channel_active = active;
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                max_count[c] <= '0;
                phase[c]     <= '0;
                remaining[c] <= '0;
            end
            tone   <= '0;
            active <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                // A write beats a coincident tick: the fresh duration is not decremented.
                if (wr_ok && bus.wr_channel == CW'(c)) begin
                    max_count[c] <= bus.wr_max_count;
                    remaining[c] <= bus.wr_duration;
                    phase[c]     <= '0;
                    tone[c]      <= 1'b0;
                    active[c]    <= |bus.wr_max_count;
                end else if (active[c] && tick && remaining[c] == DUR_WIDTH'(1)) begin
                    remaining[c] <= '0;
                    phase[c]     <= '0;
                    tone[c]      <= 1'b0;
                    active[c]    <= 1'b0;
                end else if (active[c]) begin
                    if (tick && remaining[c] != '0) remaining[c] <= remaining[c] - 1'b1;
                    phase[c] <= phase[c] == max_count[c] ? '0 : phase[c] + 1'b1;
                    if (phase[c] == max_count[c]) tone[c] <= ~tone[c];
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tick_cnt   <= '0;
            slice_cnt  <= '0;
            slot       <= '0;
            bus.buzzer <= 1'b0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            slice_cnt <= slice_end ? '0 : slice_cnt + 1'b1;
            if (slice_end) slot <= slot == CW'(CHANNELS - 1) ? '0 : slot + 1'b1;
            bus.buzzer <= mix;
        end
    end
endmodule
